// File: rtl/md5_mem_responder.sv
// md5_mem_responder: RAM-bus responder for the mdfive core. It serves the input block from a
// host-loadable buffer and captures the 128-bit digest. Define MD5_MEM_TRACE_EN for the serial digest trace.
module md5_mem_responder #(
    parameter logic [63:0] IN_BASE      = 64'h4000_0000,
    parameter logic [63:0] OUT_BASE     = 64'h4000_0100,
    parameter int unsigned IN_WORDS     = 8,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_oe,
    input  logic         mem_we,
    input  logic [63:0]  mem_addr,
    input  logic [63:0]  mem_wdata,
    input  logic [11:0]  mem_size,
    output logic [63:0]  mem_rdata,
    output logic         mem_rdy,
    input  logic         load_valid,
    output logic         load_ready,
    input  logic [2:0]   load_index,
    input  logic [63:0]  load_data,
    output logic         digest_valid,
    output logic [127:0] digest,
    input  logic         digest_ack,
    output logic         err,
    output logic         trace_bit,
    output logic         trace_busy
);

    localparam int unsigned IDX_W     = (IN_WORDS > 1) ? $clog2(IN_WORDS) : 1;
    localparam int unsigned CNT_W     = 2;
    localparam logic [63:0] IN_BYTES  = 64'(IN_WORDS) << 3;
    localparam logic [63:0] OUT_BYTES = 64'd16;
    // WAIT is only used for latencies of 2 or more; the last countdown step emits the response.
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_LATENCY - 2);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      pend_q, pend_d;
    logic [63:0]      rdata_q, rdata_d;
    logic             rdy_q, rdy_d;
    logic             err_q, err_d;
    logic [63:0]      buf_q [IN_WORDS];
    logic [127:0]     digest_q, digest_d;
    logic [1:0]       cap_q, cap_d;
    logic             valid_q, valid_d;

    logic [63:0] off_in_c, off_out_c, sel_word_c, rd_data_c;
    logic        in_hit_c, out_hit_c, half_c, size_ok_c;
    logic        rd_err_c, wr_ok_c, wr_err_c;
    logic        cap_fire_c, ack_take_c, load_hit_c, load_fire_c;

    // Address/size decode shared by reads and writes.
    always_comb begin : decode
        off_in_c   = mem_addr - IN_BASE;
        off_out_c  = mem_addr - OUT_BASE;
        in_hit_c   = off_in_c < IN_BYTES;
        out_hit_c  = off_out_c < OUT_BYTES;
        half_c     = mem_size == 12'd32;
        size_ok_c  = half_c || (mem_size == 12'd64);
        sel_word_c = 64'd0;
        if (in_hit_c) begin
            sel_word_c = buf_q[off_in_c[IDX_W+2:3]];
        end else if (out_hit_c) begin
            sel_word_c = off_out_c[3] ? digest_q[127:64] : digest_q[63:0];
        end
        if (half_c) begin
            rd_data_c = {32'd0, (mem_addr[2] ? sel_word_c[63:32] : sel_word_c[31:0])};
        end else begin
            rd_data_c = sel_word_c;
        end
        rd_err_c = !(in_hit_c || out_hit_c) || !size_ok_c;
        wr_ok_c  = out_hit_c && !half_c;
        wr_err_c = !wr_ok_c || !size_ok_c || mem_oe;
    end

    assign load_ready  = (state_q == ST_IDLE) && !mem_oe && !mem_we;
    assign load_hit_c  = (32'(load_index) >> IDX_W) == 32'd0;
    assign load_fire_c = load_valid && load_ready && load_hit_c;

    // Bus FSM: writes complete from IDLE, reads wait out the configured latency.
    always_comb begin : next_state
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        rdata_d    = rdata_q;
        rdy_d      = 1'b0;
        err_d      = err_q;
        cap_fire_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_we) begin
                    rdy_d      = 1'b1;
                    cap_fire_c = wr_ok_c;
                    if (wr_err_c) err_d = 1'b1;
                end else if (mem_oe) begin
                    if (rd_err_c) err_d = 1'b1;
                    if (READ_LATENCY <= 1) begin
                        rdy_d   = 1'b1;
                        rdata_d = rd_data_c;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LOAD;
                        pend_d  = rd_data_c;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    rdy_d   = 1'b1;
                    rdata_d = pend_q;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Digest capture; a capture in the same cycle as an ack wins and the ack is dropped.
    always_comb begin : digest_next
        digest_d   = digest_q;
        cap_d      = cap_q;
        ack_take_c = digest_ack && valid_q && !cap_fire_c;
        if (ack_take_c) cap_d = 2'b00;
        if (cap_fire_c) begin
            if (off_out_c[3]) begin
                digest_d[127:64] = mem_wdata;
                cap_d[1]         = 1'b1;
            end else begin
                digest_d[63:0] = mem_wdata;
                cap_d[0]       = 1'b1;
            end
        end
        valid_d = ack_take_c ? 1'b0 : (valid_q || (cap_q == 2'b11));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pend_q   <= '0;
            rdata_q  <= '0;
            rdy_q    <= 1'b0;
            err_q    <= 1'b0;
            digest_q <= '0;
            cap_q    <= '0;
            valid_q  <= 1'b0;
            for (int i = 0; i < int'(IN_WORDS); i++) buf_q[i] <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            rdata_q  <= rdata_d;
            rdy_q    <= rdy_d;
            err_q    <= err_d;
            digest_q <= digest_d;
            cap_q    <= cap_d;
            valid_q  <= valid_d;
            if (load_fire_c) buf_q[IDX_W'(load_index)] <= load_data;
        end
    end

    assign mem_rdata    = rdata_q;
    assign mem_rdy      = rdy_q;
    assign err          = err_q;
    assign digest       = digest_q;
    assign digest_valid = valid_q;

`ifdef MD5_MEM_TRACE_EN
    logic        tbit_q, tbusy_q;
    logic [62:0] tsh_q;
    logic [5:0]  tcnt_q;
    logic        trace_start_c;

    assign trace_start_c = valid_d && !valid_q && !tbusy_q;

    // Shift digest[63:0] out LSB first; busy covers exactly the 64 bit times.
    always_ff @(posedge clk) begin
        if (reset) begin
            tbit_q  <= 1'b0;
            tbusy_q <= 1'b0;
            tsh_q   <= '0;
            tcnt_q  <= '0;
        end else if (trace_start_c) begin
            tbit_q  <= digest_q[0];
            tsh_q   <= digest_q[63:1];
            tcnt_q  <= 6'd63;
            tbusy_q <= 1'b1;
        end else if (tbusy_q) begin
            if (tcnt_q == 6'd0) begin
                tbusy_q <= 1'b0;
                tbit_q  <= 1'b0;
            end else begin
                tbit_q <= tsh_q[0];
                tsh_q  <= {1'b0, tsh_q[62:1]};
                tcnt_q <= tcnt_q - 6'd1;
            end
        end
    end

    assign trace_bit  = tbit_q;
    assign trace_busy = tbusy_q;
`else
    assign trace_bit  = 1'b0;
    assign trace_busy = 1'b0;
`endif

endmodule

// File: tb/tb_md5_mem_responder.sv
// Self-checking bench for md5_mem_responder: two instances (read latency 1 and 3) share stimulus;
// expectations come from a behavioural memory/digest model.
`timescale 1ns/1ps
module tb_md5_mem_responder;

    localparam logic [63:0] IN_BASE  = 64'h4000_0000;
    localparam logic [63:0] OUT_BASE = 64'h4000_0100;
    localparam logic [63:0] D0 = 64'h04b2008fd98c1dd4;
    localparam logic [63:0] D1 = 64'h7e42f8ec980980e9;

    logic         clk = 1'b0;
    logic         reset, mem_oe, mem_we, load_valid, digest_ack;
    logic [63:0]  mem_addr, mem_wdata, load_data;
    logic [11:0]  mem_size;
    logic [2:0]   load_index;

    logic [63:0]  a_rdata, b_rdata;
    logic [127:0] a_digest, b_digest;
    logic         a_rdy, a_lrdy, a_dvalid, a_err, a_tbit, a_tbusy;
    logic         b_rdy, b_lrdy, b_dvalid, b_err, b_tbit, b_tbusy;

    int total = 0;
    int bad   = 0;

    logic [63:0]  m_buf [8];
    logic [127:0] m_digest;
    logic [1:0]   m_cap;
    logic         m_err;

    always #5 clk = ~clk;

    md5_mem_responder #(.READ_LATENCY(1)) dut_a (
        .clk(clk), .reset(reset), .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(a_rdata), .mem_rdy(a_rdy),
        .load_valid(load_valid), .load_ready(a_lrdy), .load_index(load_index), .load_data(load_data),
        .digest_valid(a_dvalid), .digest(a_digest), .digest_ack(digest_ack), .err(a_err),
        .trace_bit(a_tbit), .trace_busy(a_tbusy));

    md5_mem_responder #(.READ_LATENCY(3)) dut_b (
        .clk(clk), .reset(reset), .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_size(mem_size), .mem_rdata(b_rdata), .mem_rdy(b_rdy),
        .load_valid(load_valid), .load_ready(b_lrdy), .load_index(load_index), .load_data(load_data),
        .digest_valid(b_dvalid), .digest(b_digest), .digest_ack(digest_ack), .err(b_err),
        .trace_bit(b_tbit), .trace_busy(b_tbusy));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    // ---------------- stimulus helpers (no checking) ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_oe = 0; mem_we = 0; mem_addr = '0; mem_wdata = '0; mem_size = 12'd64;
        load_valid = 0; load_index = '0; load_data = '0; digest_ack = 0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m_buf[i] = '0;
        m_digest = '0; m_cap = 2'b00; m_err = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1;
        step();
        step();
        reset = 0;
        model_clear();
    endtask

    task automatic load_word(input int idx, input logic [63:0] data);
        load_valid = 1; load_index = 3'(idx); load_data = data;
        step();
        load_valid = 0;
        m_buf[idx] = data;
    endtask

    // Drives one single-cycle request and waits (bounded) for the chosen instance's mem_rdy.
    task automatic bus_op(input bit use_b, input bit oe, input bit we, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [11:0] size,
                          output int lat, output logic [63:0] data);
        bit found = 0;
        mem_oe = oe; mem_we = we; mem_addr = addr; mem_wdata = wdata; mem_size = size;
        step();
        mem_oe = 0; mem_we = 0;
        lat = -1; data = '0;
        for (int c = 1; c <= 10 && !found; c++) begin
            if ((use_b ? b_rdy : a_rdy) === 1'b1) begin
                found = 1; lat = c; data = use_b ? b_rdata : a_rdata;
            end else begin
                step();
            end
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit in_region(input logic [63:0] addr);
        return addr >= IN_BASE && addr < IN_BASE + 64'd64;
    endfunction

    function automatic bit out_region(input logic [63:0] addr);
        return addr >= OUT_BASE && addr < OUT_BASE + 64'd16;
    endfunction

    function automatic logic [63:0] model_read(input logic [63:0] addr, input logic [11:0] size);
        logic [63:0] w;
        w = '0;
        if (in_region(addr)) w = m_buf[int'((addr - IN_BASE) >> 3)];
        else if (out_region(addr)) w = (addr - OUT_BASE >= 64'd8) ? m_digest[127:64] : m_digest[63:0];
        if (size == 12'd32) return addr[2] ? {32'd0, w[63:32]} : {32'd0, w[31:0]};
        return w;
    endfunction

    task automatic model_rd_err(input logic [63:0] addr, input logic [11:0] size);
        if (!(in_region(addr) || out_region(addr)) || !(size == 12'd32 || size == 12'd64)) m_err = 1;
    endtask

    task automatic model_write(input logic [63:0] addr, input logic [63:0] data, input logic [11:0] size);
        if (out_region(addr) && size != 12'd32) begin
            if (addr - OUT_BASE >= 64'd8) begin m_digest[127:64] = data; m_cap[1] = 1; end
            else begin m_digest[63:0] = data; m_cap[0] = 1; end
            if (size != 12'd64) m_err = 1;
        end else begin
            m_err = 1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++;
        if ({a_rdy, a_dvalid, a_err, a_tbit, a_tbusy} !== 5'b0) begin
            bad++; $display("FAIL reset_flags: got %b want 00000", {a_rdy, a_dvalid, a_err, a_tbit, a_tbusy});
        end
        total++;
        if (a_rdata !== 64'd0 || a_digest !== 128'd0) begin
            bad++; $display("FAIL reset_data: rdata=%h digest=%h want 0", a_rdata, a_digest);
        end
        total++;
        if (a_lrdy !== 1'b1) begin bad++; $display("FAIL reset_load_ready: got %b want 1", a_lrdy); end
        total++;
        if ({b_rdy, b_dvalid, b_err} !== 3'b0) begin
            bad++; $display("FAIL reset_b_flags: got %b want 000", {b_rdy, b_dvalid, b_err});
        end
    endtask

    task automatic test_read_basic();
        int lat; logic [63:0] d;
        load_word(0, 64'h80);
        for (int i = 1; i < 8; i++) load_word(i, 64'd0);
        // A load presented together with a bus read must be refused.
        mem_oe = 1; mem_addr = IN_BASE + 64'd8; mem_size = 12'd64;
        load_valid = 1; load_index = 3'd1; load_data = 64'hdead_beef_0000_0001;
        #1;
        total++;
        if (a_lrdy !== 1'b0) begin bad++; $display("FAIL load_ready_busy: got %b want 0", a_lrdy); end
        step();
        mem_oe = 0; load_valid = 0;
        total++;
        if (a_rdy !== 1'b1 || a_rdata !== 64'd0) begin
            bad++; $display("FAIL read_idx1_first: rdy=%b rdata=%h want 1/0", a_rdy, a_rdata);
        end
        bus_op(0, 1, 0, IN_BASE, '0, 12'd64, lat, d);
        total++;
        if (lat !== 1 || d !== 64'h80) begin bad++; $display("FAIL read_idx0: lat=%0d data=%h want 1/80", lat, d); end
        bus_op(0, 1, 0, IN_BASE + 64'd8, '0, 12'd64, lat, d);
        total++;
        if (lat !== 1 || d !== 64'd0) begin bad++; $display("FAIL read_idx1: lat=%0d data=%h want 1/0", lat, d); end
        total++;
        if (a_err !== 1'b0) begin bad++; $display("FAIL read_basic_err: got %b want 0", a_err); end
    endtask

    task automatic test_digest();
        int lat; logic [63:0] d, bits;
        int busy_bad;
        bus_op(0, 0, 1, OUT_BASE, D0, 12'd64, lat, d);
        total++;
        if (lat !== 1 || a_dvalid !== 1'b0) begin bad++; $display("FAIL digest_w0: lat=%0d valid=%b want 1/0", lat, a_dvalid); end
        bus_op(0, 0, 1, OUT_BASE + 64'd8, D1, 12'd64, lat, d);
        total++;
        if (lat !== 1 || a_dvalid !== 1'b0) begin bad++; $display("FAIL digest_w1: lat=%0d valid=%b want 1/0", lat, a_dvalid); end
        step();
        total++;
        if (a_dvalid !== 1'b1 || a_digest !== {D1, D0} || a_err !== 1'b0) begin
            bad++; $display("FAIL digest_value: valid=%b digest=%h err=%b want 1/%h/0", a_dvalid, a_digest, a_err, {D1, D0});
        end
`ifdef MD5_MEM_TRACE_EN
        busy_bad = 0; bits = '0;
        for (int i = 0; i < 64; i++) begin
            if (a_tbusy !== 1'b1) busy_bad++;
            bits[i] = a_tbit;
            step();
        end
        total++;
        if (busy_bad != 0 || a_tbusy !== 1'b0) begin
            bad++; $display("FAIL trace_busy: low during %0d of 64 cycles, after=%b want 0/0", busy_bad, a_tbusy);
        end
        total++;
        if (bits !== D0) begin bad++; $display("FAIL trace_bits: got %h want %h", bits, D0); end
`else
        busy_bad = 0; bits = '0;
        for (int i = 0; i < 8; i++) begin
            if (a_tbusy !== 1'b0 || a_tbit !== 1'b0) busy_bad++;
            step();
        end
        total++;
        if (busy_bad != 0) begin bad++; $display("FAIL trace_tied: nonzero in %0d cycles want 0", busy_bad); end
`endif
        bus_op(0, 1, 0, OUT_BASE + 64'd8, '0, 12'd64, lat, d);
        total++;
        if (d !== D1) begin bad++; $display("FAIL digest_readback: got %h want %h", d, D1); end
        digest_ack = 1;
        step();
        digest_ack = 0;
        total++;
        if (a_dvalid !== 1'b0) begin bad++; $display("FAIL digest_ack_clear: got %b want 0", a_dvalid); end
    endtask

    task automatic test_errors();
        int lat; logic [63:0] d;
        do_reset();
        bus_op(0, 1, 0, 64'h5000_0000, '0, 12'd64, lat, d);
        total++;
        if (lat !== 1 || d !== 64'd0 || a_err !== 1'b1) begin
            bad++; $display("FAIL bad_addr_read: lat=%0d data=%h err=%b want 1/0/1", lat, d, a_err);
        end
        bus_op(0, 1, 0, IN_BASE, '0, 12'd64, lat, d);
        total++;
        if (a_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", a_err); end
        do_reset();
        bus_op(0, 1, 1, OUT_BASE, 64'h0123_4567_89ab_cdef, 12'd64, lat, d);
        total++;
        if (lat !== 1 || a_err !== 1'b1 || a_digest[63:0] !== 64'h0123_4567_89ab_cdef) begin
            bad++; $display("FAIL oe_we_both: lat=%0d err=%b dig0=%h want 1/1/0123456789abcdef", lat, a_err, a_digest[63:0]);
        end
        do_reset();
        bus_op(0, 0, 1, IN_BASE, 64'h55, 12'd64, lat, d);
        bus_op(0, 1, 0, IN_BASE, '0, 12'd64, lat, d);
        total++;
        if (d !== 64'd0 || a_err !== 1'b1) begin bad++; $display("FAIL in_write_drop: data=%h err=%b want 0/1", d, a_err); end
        do_reset();
        load_word(2, 64'hfeed_face_cafe_f00d);
        bus_op(0, 1, 0, IN_BASE + 64'd16, '0, 12'd16, lat, d);
        total++;
        if (d !== 64'hfeed_face_cafe_f00d || a_err !== 1'b1) begin
            bad++; $display("FAIL bad_size: data=%h err=%b want feedfacecafef00d/1", d, a_err);
        end
    endtask

    task automatic test_latency3();
        int lat; logic [63:0] d;
        do_reset();
        load_word(0, 64'h1122_3344_5566_7788);
        bus_op(1, 1, 0, IN_BASE + 64'd4, '0, 12'd32, lat, d);
        total++;
        if (lat !== 3 || d !== 64'h1122_3344) begin bad++; $display("FAIL lat3_read: lat=%0d data=%h want 3/11223344", lat, d); end
        bus_op(0, 1, 0, IN_BASE, '0, 12'd32, lat, d);
        total++;
        if (lat !== 1 || d !== 64'h5566_7788) begin bad++; $display("FAIL lat1_half_lo: lat=%0d data=%h want 1/55667788", lat, d); end
    endtask

    task automatic test_reset_wait();
        int lat, seen; logic [63:0] d;
        do_reset();
        load_word(3, 64'habcd);
        mem_oe = 1; mem_addr = IN_BASE + 64'd24; mem_size = 12'd64;
        step();
        mem_oe = 0;
        step();
        reset = 1;
        step();
        reset = 0;
        model_clear();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (b_rdy !== 1'b0 || b_rdata !== 64'd0 || b_err !== 1'b0 || b_dvalid !== 1'b0) seen++;
            step();
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL reset_in_wait: outputs nonzero in %0d cycles want 0", seen); end
        // Capture coinciding with ack while valid: valid holds.
        bus_op(0, 0, 1, OUT_BASE, D0, 12'd64, lat, d);
        bus_op(0, 0, 1, OUT_BASE + 64'd8, D1, 12'd64, lat, d);
        step();
        mem_we = 1; mem_addr = OUT_BASE; mem_wdata = 64'h99; mem_size = 12'd64; digest_ack = 1;
        step();
        mem_we = 0; digest_ack = 0;
        step();
        total++;
        if (a_dvalid !== 1'b1 || a_digest[63:0] !== 64'h99) begin
            bad++; $display("FAIL ack_vs_capture: valid=%b dig0=%h want 1/99", a_dvalid, a_digest[63:0]);
        end
        digest_ack = 1;
        step();
        digest_ack = 0;
        // Ack arriving with the second capture of a fresh digest: valid still rises.
        bus_op(0, 0, 1, OUT_BASE, D0, 12'd64, lat, d);
        mem_we = 1; mem_addr = OUT_BASE + 64'd8; mem_wdata = D1; digest_ack = 1;
        step();
        mem_we = 0; digest_ack = 0;
        step();
        step();
        total++;
        if (a_dvalid !== 1'b1 || a_digest !== {D1, D0}) begin
            bad++; $display("FAIL ack_with_2nd_capture: valid=%b digest=%h want 1/%h", a_dvalid, a_digest, {D1, D0});
        end
    endtask

    task automatic test_random();
        int lat, kind; logic [63:0] d, addr, data; logic [11:0] size;
        do_reset();
        for (int i = 0; i < 8; i++) load_word(i, {$urandom, $urandom});
        for (int it = 0; it < 120; it++) begin
            kind = $urandom_range(0, 5);
            case ($urandom_range(0, 3))
                0: size = 12'd32;
                1: size = 12'd8;
                default: size = 12'd64;
            endcase
            if (kind <= 2) begin
                if (kind == 0) addr = IN_BASE + 64'($urandom_range(0, 15)) * 64'd4;
                else if (kind == 1) addr = OUT_BASE + 64'($urandom_range(0, 3)) * 64'd4;
                else addr = IN_BASE + 64'd64 + 64'($urandom_range(0, 23)) * 64'd8;
                bus_op(0, 1, 0, addr, '0, size, lat, d);
                model_rd_err(addr, size);
                total++;
                if (lat !== 1 || d !== model_read(addr, size) || a_err !== m_err) begin
                    bad++; $display("FAIL rand_read it=%0d addr=%h size=%0d: lat=%0d data=%h err=%b want 1/%h/%b",
                                    it, addr, size, lat, d, a_err, model_read(addr, size), m_err);
                end
            end else if (kind <= 4) begin
                addr = (kind == 3) ? OUT_BASE + 64'($urandom_range(0, 1)) * 64'd8
                                   : IN_BASE + 64'($urandom_range(0, 7)) * 64'd8;
                if (kind == 3 && size == 12'd32) size = 12'd64;
                data = {$urandom, $urandom};
                bus_op(0, 0, 1, addr, data, size, lat, d);
                model_write(addr, data, size);
                step();
                total++;
                if (lat !== 1 || a_err !== m_err || a_digest !== m_digest || a_dvalid !== (m_cap == 2'b11)) begin
                    bad++; $display("FAIL rand_write it=%0d addr=%h: lat=%0d err=%b digest=%h valid=%b want 1/%b/%h/%b",
                                    it, addr, lat, a_err, a_digest, a_dvalid, m_err, m_digest, m_cap == 2'b11);
                end
            end else if (m_cap == 2'b11) begin
                digest_ack = 1;
                step();
                digest_ack = 0;
                m_cap = 2'b00;
                total++;
                if (a_dvalid !== 1'b0) begin bad++; $display("FAIL rand_ack it=%0d: valid=%b want 0", it, a_dvalid); end
            end else begin
                load_word($urandom_range(0, 7), {$urandom, $urandom});
            end
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        model_clear();
        test_reset();
        test_read_basic();
        test_digest();
        test_errors();
        test_latency3();
        test_reset_wait();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
